dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single 16-bit data-memory port (address, read/write strobe, data).
- Port 0 is the CPU data port; port 1 is a secondary master (loader/DMA).
- Grants one requester at a time and drives the memory address, strobe and write data.
- Returns read data with a one-cycle acknowledge; programmable wait states cover slower memories.

---
 rtl/dmem_arbiter_if.sv | 69 ++++++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports and the single data-memory port that the
//   dmem_arbiter connects.
//
//   Requester port n (n = 0 CPU, n = 1 loader/DMA):
//     reqn   request, held until ackn
//     rwn    direction, 1 = read, 0 = write
//     an     address
//     wdn    write data
//     rdn    read data, valid while ackn = 1
//     ackn   one-cycle completion pulse
//   Memory port:
//     ma     memory address
//     mrw    memory strobe, 1 = read/idle, 0 = write
//     mwd    memory write data
//     mrd    memory read data, valid in the cycle MA/MRW are presented
//   Status:
//     gnt    owner of the current/last transaction
//     busy   transaction in progress
//
//   Modports: slave = arbiter side, master = requester/memory side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req0;
    logic          rw0;
    logic [AW-1:0] a0;
    logic [DW-1:0] wd0;
    logic [DW-1:0] rd0;
    logic          ack0;

    logic          req1;
    logic          rw1;
    logic [AW-1:0] a1;
    logic [DW-1:0] wd1;
    logic [DW-1:0] rd1;
    logic          ack1;

    logic [AW-1:0] ma;
    logic          mrw;
    logic [DW-1:0] mwd;
    logic [DW-1:0] mrd;

    logic          gnt;
    logic          busy;

    modport slave (
        input  req0, rw0, a0, wd0,
        output rd0, ack0,
        input  req1, rw1, a1, wd1,
        output rd1, ack1,
        output ma, mrw, mwd,
        input  mrd,
        output gnt, busy
    );

    modport master (
        output req0, rw0, a0, wd0,
        input  rd0, ack0,
        output req1, rw1, a1, wd1,
        input  rd1, ack1,
        input  ma, mrw, mwd,
        output mrd,
        input  gnt, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter and sequencer for a single data-memory port. Port 0 is the
//   CPU data port, port 1 a secondary master. One requester is granted at a
//   time; its address, direction and write data are latched at grant and held
//   on the memory port for 1+WAIT access cycles, after which read data is
//   captured and a one-cycle acknowledge is returned.
//
//   Ports:
//     clk_i  clock, all state changes on posedge
//     rst_i  asynchronous active-high reset
//     bus    dmem_arbiter_if.slave (requester ports, memory port, status)
//
//   Parameters:
//     AW, DW  address / data width
//     WAIT    extra memory wait cycles per access (0..15)
//
//   Build option:
//     DMEM_ARB_ROUND_ROBIN_EN  defined: round-robin between the ports under
//                              contention; undefined: port 0 fixed priority.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int WAIT = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_e;

    // The wait counter is 4 bits; WAIT above 15 is a configuration error.
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_e        state_q, state_d;
    logic [AW-1:0] ma_q, ma_d;
    logic          mrw_q, mrw_d;
    logic [DW-1:0] mwd_q, mwd_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          gnt_q, gnt_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          win;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Last-served port; resets to 1 so port 0 wins the first contention.
    logic          last_q, last_d;

    always_comb begin
        if (bus.req0 && bus.req1) win = ~last_q;
        else                      win = ~bus.req0;
    end
`else
    // Fixed priority: port 1 wins only when port 0 is not requesting.
    always_comb win = ~bus.req0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ma_q    <= '0;
            mrw_q   <= 1'b1;
            mwd_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mrw_q   <= mrw_d;
            mwd_q   <= mwd_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // NOTE: every next-state variable is given its hold value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mrw_d   = mrw_q;
        mwd_d   = mwd_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                mrw_d = 1'b1;
                if (bus.req0 || bus.req1) begin
                    gnt_d   = win;
                    ma_d    = win ? bus.a1  : bus.a0;
                    mrw_d   = win ? bus.rw1 : bus.rw0;
                    mwd_d   = win ? bus.wd1 : bus.wd0;
                    cnt_d   = WAIT_CNT;
                    state_d = S_ACC;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    last_d  = win;
`endif
                end
            end

            S_ACC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Final access cycle: a write commits on this edge, a
                    // read's data is captured for the winner only.
                    state_d = S_DONE;
                    mrw_d   = 1'b1;
                    if (mrw_q) begin
                        if (gnt_q) rd1_d = bus.mrd;
                        else       rd0_d = bus.mrd;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Acknowledge is the DONE state qualified by the owner, so it lasts one
    // cycle and can never be high on both ports.
    assign bus.ack0 = (state_q == S_DONE) && !gnt_q;
    assign bus.ack1 = (state_q == S_DONE) &&  gnt_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.gnt  = gnt_q;
    assign bus.ma   = ma_q;
    assign bus.mrw  = mrw_q;
    assign bus.mwd  = mwd_q;
    assign bus.rd0  = rd0_q;
    assign bus.rd1  = rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Instance A runs with WAIT=0, instance B
//   with WAIT=3. Each has a small memory model: combinational read, write on
//   the clock edge while MRW=0, plus a preload path used only while idle.
//   Honours DMEM_ARB_ROUND_ROBIN_EN for the contention ordering.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];

    dmem_arbiter_if #(.AW(16), .DW(16)) bus_a ();
    dmem_arbiter_if #(.AW(16), .DW(16)) bus_b ();

    dmem_arbiter #(.AW(16), .DW(16), .WAIT(0)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a.slave)
    );

    dmem_arbiter #(.AW(16), .DW(16), .WAIT(3)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_a.mrd = mem_a[bus_a.ma[7:0]];
    assign bus_b.mrd = mem_b[bus_b.ma[7:0]];

    always @(posedge clk) begin
        if (pl_en)           mem_a[pl_addr]        <= pl_data;
        else if (!bus_a.mrw) mem_a[bus_a.ma[7:0]]  <= bus_a.mwd;
    end

    always @(posedge clk) begin
        if (pl_en)           mem_b[pl_addr]        <= pl_data;
        else if (!bus_b.mrw) mem_b[bus_b.ma[7:0]]  <= bus_b.mwd;
    end

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [15:0] data);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    int          order_obs [8];
    int          order_exp [8];
    int          n_ack;
    int          n_ack0;
    int          n_ack1;
    int          n_rd;
    int          last_ack_cyc;
    logic [15:0] b2b_data [3];

    initial begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        order_exp = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        order_exp = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        b2b_data = '{16'h0011, 16'h0022, 16'h0033};

        rst     = 1'b1;
        pl_en   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        bus_a.req0 = 1'b0; bus_a.rw0 = 1'b1; bus_a.a0 = '0; bus_a.wd0 = '0;
        bus_a.req1 = 1'b0; bus_a.rw1 = 1'b1; bus_a.a1 = '0; bus_a.wd1 = '0;
        bus_b.req0 = 1'b0; bus_b.rw0 = 1'b1; bus_b.a0 = '0; bus_b.wd0 = '0;
        bus_b.req1 = 1'b0; bus_b.rw1 = 1'b1; bus_b.a1 = '0; bus_b.wd1 = '0;

        // Reset values while RST is high.
        #50;
        check16("rst_ma",   bus_a.ma,   16'h0000);
        check1 ("rst_mrw",  bus_a.mrw,  1'b1);
        check16("rst_mwd",  bus_a.mwd,  16'h0000);
        check16("rst_rd0",  bus_a.rd0,  16'h0000);
        check16("rst_rd1",  bus_a.rd1,  16'h0000);
        check1 ("rst_ack0", bus_a.ack0, 1'b0);
        check1 ("rst_ack1", bus_a.ack1, 1'b0);
        check1 ("rst_gnt",  bus_a.gnt,  1'b0);
        check1 ("rst_busy", bus_a.busy, 1'b0);
        #50;
        rst = 1'b0;
        tick();

        // Single write, port 0, WAIT=0.
        bus_a.req0 = 1'b1; bus_a.rw0 = 1'b0; bus_a.a0 = 16'h0000; bus_a.wd0 = 16'h0004;
        tick();
        check16("wr_ma",      bus_a.ma,   16'h0000);
        check1 ("wr_mrw_acc", bus_a.mrw,  1'b0);
        check16("wr_mwd",     bus_a.mwd,  16'h0004);
        check1 ("wr_gnt",     bus_a.gnt,  1'b0);
        check1 ("wr_busy",    bus_a.busy, 1'b1);
        check1 ("wr_ack_acc", bus_a.ack0, 1'b0);
        tick();
        check1 ("wr_ack",      bus_a.ack0, 1'b1);
        check1 ("wr_mrw_done", bus_a.mrw,  1'b1);
        check1 ("wr_ack1_low", bus_a.ack1, 1'b0);
        bus_a.req0 = 1'b0;
        tick();
        check1 ("wr_ack_end",  bus_a.ack0, 1'b0);
        check1 ("wr_idle",     bus_a.busy, 1'b0);
        check16("wr_mem0",     mem_a[0],   16'h0004);

        // Single read, port 1.
        preload(8'h03, 16'h0003);
        bus_a.req1 = 1'b1; bus_a.rw1 = 1'b1; bus_a.a1 = 16'h0003;
        tick();
        check1 ("rd_gnt",     bus_a.gnt,  1'b1);
        check16("rd_ma",      bus_a.ma,   16'h0003);
        check1 ("rd_mrw_acc", bus_a.mrw,  1'b1);
        check1 ("rd_ack_acc", bus_a.ack1, 1'b0);
        tick();
        check1 ("rd_ack",      bus_a.ack1, 1'b1);
        check16("rd_data",     bus_a.rd1,  16'h0003);
        check1 ("rd_mrw_done", bus_a.mrw,  1'b1);
        check1 ("rd_ack0_low", bus_a.ack0, 1'b0);
        check16("rd_rd0_hold", bus_a.rd0,  16'h0000);
        bus_a.req1 = 1'b0;
        tick();
        check1 ("rd_ack_end", bus_a.ack1, 1'b0);
        check1 ("rd_idle",    bus_a.busy, 1'b0);

        // Contention: both ports write, four transactions each.
        bus_a.req0 = 1'b1; bus_a.rw0 = 1'b0; bus_a.a0 = 16'h0020; bus_a.wd0 = 16'h00A0;
        bus_a.req1 = 1'b1; bus_a.rw1 = 1'b0; bus_a.a1 = 16'h0030; bus_a.wd1 = 16'h00B0;
        n_ack = 0; n_ack0 = 0; n_ack1 = 0;
        for (int c = 0; c < 40 && n_ack < 8; c++) begin
            tick();
            if (bus_a.ack0 && bus_a.ack1) check1("ct_both_ack", 1'b1, 1'b0);
            if (bus_a.ack0 || bus_a.ack1) begin
                order_obs[n_ack] = bus_a.ack1 ? 1 : 0;
                n_ack++;
                if (bus_a.ack0) n_ack0++;
                if (bus_a.ack1) n_ack1++;
                if (n_ack0 == 4) bus_a.req0 = 1'b0;
                if (n_ack1 == 4) bus_a.req1 = 1'b0;
            end
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        check16("ct_count", 16'(n_ack), 16'd8);
        for (int i = 0; i < n_ack; i++)
            check16($sformatf("ct_order%0d", i), 16'(order_obs[i]), 16'(order_exp[i]));
        check16("ct_mem20", mem_a[8'h20], 16'h00A0);
        check16("ct_mem30", mem_a[8'h30], 16'h00B0);
        tick();
        tick();

        // Wait states: WAIT=3 read of 0x0005 on instance B.
        preload(8'h05, 16'h0055);
        bus_b.req0 = 1'b1; bus_b.rw0 = 1'b1; bus_b.a0 = 16'h0005;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check1($sformatf("ws_busy%0d", i), bus_b.busy, (i <= 5));
            check1($sformatf("ws_ack%0d", i),  bus_b.ack0, (i == 5));
            if (i <= 4) check16($sformatf("ws_ma%0d", i), bus_b.ma, 16'h0005);
            if (i == 5) begin
                check16("ws_data", bus_b.rd0, 16'h0055);
                bus_b.req0 = 1'b0;
            end
        end

        // Reset during the first ACC cycle of a WAIT=3 write.
        preload(8'h10, 16'h1234);
        bus_b.req0 = 1'b1; bus_b.rw0 = 1'b0; bus_b.a0 = 16'h0010; bus_b.wd0 = 16'hDEAD;
        tick();
        check1("rs_mrw_acc", bus_b.mrw, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check1("rs_mrw_async",  bus_b.mrw,  1'b1);
        check1("rs_busy_async", bus_b.busy, 1'b0);
        bus_b.req0 = 1'b0;
        tick();
        check1("rs_ack_held", bus_b.ack0, 1'b0);
        tick();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check1($sformatf("rs_ack%0d", i), bus_b.ack0, 1'b0);
        end
        check1 ("rs_idle", bus_b.busy,    1'b0);
        check16("rs_mem",  mem_b[8'h10],  16'h1234);

        // Back-to-back reads on port 0, request held throughout.
        preload(8'h01, 16'h0011);
        preload(8'h02, 16'h0022);
        preload(8'h03, 16'h0033);
        bus_a.req0 = 1'b1; bus_a.rw0 = 1'b1; bus_a.a0 = 16'h0001;
        n_rd = 0;
        last_ack_cyc = 0;
        for (int c = 1; c <= 20 && n_rd < 3; c++) begin
            tick();
            if (bus_a.ack1) check1("bb_ack1", bus_a.ack1, 1'b0);
            if (bus_a.ack0) begin
                check16($sformatf("bb_data%0d", n_rd), bus_a.rd0, b2b_data[n_rd]);
                if (n_rd > 0) check16($sformatf("bb_gap%0d", n_rd), 16'(c - last_ack_cyc), 16'd3);
                last_ack_cyc = c;
                n_rd++;
                if (n_rd < 3) bus_a.a0 = 16'(n_rd + 1);
                else          bus_a.req0 = 1'b0;
            end
        end
        bus_a.req0 = 1'b0;
        check16("bb_count", 16'(n_rd), 16'd3);
        tick();
        tick();
        check1("bb_idle", bus_a.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
